// File: rtl/pool_pkg.sv
// Shared types and sizes for the input max-pooling stage.
// Optional build macro POOL_AVG_EN switches the window reduction from max to average,
// which widens the line-buffer and hold registers to carry partial sums.
package pool_pkg;

    localparam int unsigned IMG_W    = 28;
    localparam int unsigned IMG_H    = 28;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned OUT_W    = 16;
    localparam int unsigned POOLED_X = IMG_W / 2;
    localparam int unsigned POOLED_N = (IMG_W / 2) * (IMG_H / 2);
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned IDX_W    = 8;
    localparam int unsigned LB_A_W   = 4;

`ifdef POOL_AVG_EN
    // Line buffer holds a two-pixel sum; hold carries a three-pixel sum on odd rows.
    localparam int unsigned LB_W     = PIX_W + 1;
    localparam int unsigned HOLD_W   = PIX_W + 2;
`else
    localparam int unsigned LB_W     = PIX_W;
    localparam int unsigned HOLD_W   = PIX_W;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } pool_state_t;

    typedef logic signed [OUT_W-1:0] pooled_arr_t [0:POOLED_N-1];

    // Flattened pooled index of the window containing pixel (row, col).
    function automatic logic [IDX_W-1:0] pooled_idx(input logic [CNT_W-1:0] row,
                                                    input logic [CNT_W-1:0] col);
        return IDX_W'(row[CNT_W-1:1]) * IDX_W'(POOLED_X) + IDX_W'(col[CNT_W-1:1]);
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer of even-row partial window results, one entry per pooled column.
// Ports: clk, reset (async active-low), clr (sync clear), wr_en/wr_idx/wr_data (sync write),
// rd_idx/rd_data_c (combinational read).
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int unsigned W   = LB_W,
    parameter int unsigned N   = POOLED_X,
    parameter int unsigned A_W = LB_A_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           wr_en,
    input  logic [A_W-1:0] wr_idx,
    input  logic [W-1:0]   wr_data,
    input  logic [A_W-1:0] rd_idx,
    output logic [W-1:0]   rd_data_c
);

    logic [W-1:0] mem [N];

    // Storage with clear-on-frame-start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N); i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(N); i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/max_pool_layer.sv
// 2x2 stride-2 pooling of a 28x28 8-bit frame streamed in raster order into a
// 196-entry signed 16-bit array; each result is the window max shifted right by one.
// Build macro POOL_AVG_EN: average pooling (window sum >> 3) instead of max.
// Ports: clk, reset (async active-low), start, pix_valid/pix_data/pix_ready (pixel stream),
// pooled_img (result array), pool_done (frame complete, level), busy (capturing).
module max_pool_layer
    import pool_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output pooled_arr_t      pooled_img,
    output logic             pool_done,
    output logic             busy
);

    pool_state_t       state;
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;
    logic [HOLD_W-1:0] hold;

    logic              accept_c;
    logic              clr_c;
    logic              last_c;
    logic [LB_W-1:0]   lb_rd_c;
    logic [LB_W-1:0]   lb_wr_c;
    logic [HOLD_W-1:0] hold_odd_c;
    logic [HOLD_W-1:0] win_c;
    logic [OUT_W-1:0]  res_c;

    assign accept_c = (state == CAPTURE) && pix_valid;
    assign clr_c    = (state != CAPTURE) && start;
    assign last_c   = (row == CNT_W'(IMG_H - 1)) && (col == CNT_W'(IMG_W - 1));

    pool_line_buf u_line_buf (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr_c),
        .wr_en     (accept_c && !row[0] && col[0]),
        .wr_idx    (col[CNT_W-1:1]),
        .wr_data   (lb_wr_c),
        .rd_idx    (col[CNT_W-1:1]),
        .rd_data_c (lb_rd_c)
    );

    // Window reduction: partial result for the line buffer, odd-row hold, final result.
    always_comb begin
        lb_wr_c    = '0;
        hold_odd_c = '0;
        win_c      = '0;
        res_c      = '0;
`ifdef POOL_AVG_EN
        lb_wr_c    = LB_W'(hold) + LB_W'(pix_data);
        hold_odd_c = HOLD_W'(lb_rd_c) + HOLD_W'(pix_data);
        win_c      = hold + HOLD_W'(pix_data);
        res_c      = OUT_W'(win_c >> 3);
`else
        lb_wr_c    = (hold > pix_data) ? hold : pix_data;
        hold_odd_c = (lb_rd_c > pix_data) ? lb_rd_c : pix_data;
        win_c      = (hold > pix_data) ? hold : pix_data;
        res_c      = OUT_W'(win_c >> 1);
`endif
    end

    // Control FSM, raster counters, hold register and result array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            hold      <= '0;
            pix_ready <= 1'b0;
            busy      <= 1'b0;
            pool_done <= 1'b0;
            for (int i = 0; i < int'(POOLED_N); i++) pooled_img[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= CAPTURE;
                        row       <= '0;
                        col       <= '0;
                        hold      <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                        pool_done <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (pix_valid) begin
                        if (!col[0]) begin
                            hold <= row[0] ? hold_odd_c : HOLD_W'(pix_data);
                        end
                        if (row[0] && col[0]) begin
                            pooled_img[pooled_idx(row, col)] <= res_c;
                        end
                        if (col == CNT_W'(IMG_W - 1)) begin
                            col <= '0;
                            row <= last_c ? '0 : row + CNT_W'(1);
                        end else begin
                            col <= col + CNT_W'(1);
                        end
                        if (last_c) begin
                            state     <= DONE;
                            pix_ready <= 1'b0;
                            busy      <= 1'b0;
                            pool_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                    pool_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
